csc_src_arb: RTL

//  Frame-level arbiter sharing one csc instance between two pixel stream sources.

---
 rtl/csc_src_arb.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/csc_src_arb.sv
// Frame-level arbiter sharing one csc between two pixel sources; grants whole F..L frames round-robin.
// Latency: 1-cycle grant in IDLE, then data/flags combinational. Backpressure: csc bsy routed to granted source only.
module csc_src_arb #(
  parameter int W    = 16,
  parameter int MAXB = 4096,
  parameter int CW   = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3*W-1:0] s0_d,
  input  logic [3:0]     s0_mflags,
  output logic [1:0]     s0_sflags,
  input  logic [3*W-1:0] s1_d,
  input  logic [3:0]     s1_mflags,
  output logic [1:0]     s1_sflags,
  output logic [3*W-1:0] x_d,
  output logic [3:0]     x_mflags,
  input  logic [1:0]     dc_sflags,
  output logic           csel,
  output logic           err_orphan,
  output logic           err_wdog,
  input  logic           clr_err
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(MAXB - 1);

  state_t        state;
  logic          rr_last;
  logic [CW-1:0] cnt;

  logic           locked;
  logic           lock_src;
  logic [3*W-1:0] sel_d;
  logic [3:0]     sel_mf;
  logic           dc_bsy;
  logic           unused_dc_rsvd;

  logic req0, req1;
  logic gnt0, gnt1;
  logic orph0, orph1;
  logic wdog_hit;
  logic lock_xfer;
  logic rel_beat;
  logic set_orph;
  logic set_wdog;

  assign locked         = (state == LOCK0) || (state == LOCK1);
  assign lock_src       = (state == LOCK1);
  assign sel_d          = lock_src ? s1_d : s0_d;
  assign sel_mf         = lock_src ? s1_mflags : s0_mflags;
  assign dc_bsy         = dc_sflags[0];
  assign unused_dc_rsvd = dc_sflags[1];

  // Arbitration looks only at V and F; A is deliberately ignored.
  assign req0 = s0_mflags[0] & s0_mflags[2];
  assign req1 = s1_mflags[0] & s1_mflags[2];
  assign gnt1 = req1 & (~req0 | ~rr_last);
  assign gnt0 = req0 & ~gnt1;

  assign orph0 = (state == IDLE) & s0_mflags[0] & ~s0_mflags[2];
  assign orph1 = (state == IDLE) & s1_mflags[0] & ~s1_mflags[2];

  // Watchdog depends only on registered cnt, so dc_sflags never reaches x_mflags.
  assign wdog_hit  = locked & (cnt == CNT_LAST);
  assign lock_xfer = locked & sel_mf[0] & ~dc_bsy;
  assign rel_beat  = lock_xfer & (sel_mf[1] | wdog_hit);
  assign set_orph  = orph0 | orph1;
  assign set_wdog  = lock_xfer & wdog_hit & ~sel_mf[1];

  // Reset is also applied here so the outputs snap to their idle values the moment rst_n drops.
  always_comb begin
    x_d       = '0;
    x_mflags  = 4'h0;
    s0_sflags = 2'b01;
    s1_sflags = 2'b01;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (orph0) s0_sflags = 2'b00;
          if (orph1) s1_sflags = 2'b00;
        end
        LOCK0: begin
          x_d       = sel_d;
          x_mflags  = sel_mf | {2'b00, wdog_hit & sel_mf[0], 1'b0};
          s0_sflags = {1'b0, dc_bsy};
        end
        LOCK1: begin
          x_d       = sel_d;
          x_mflags  = sel_mf | {2'b00, wdog_hit & sel_mf[0], 1'b0};
          s1_sflags = {1'b0, dc_bsy};
        end
        default: begin
          x_d      = '0;
          x_mflags = 4'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      csel       <= 1'b0;
      cnt        <= '0;
      err_orphan <= 1'b0;
      err_wdog   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0) begin
            state <= LOCK0;
            csel  <= 1'b0;
          end else if (gnt1) begin
            state <= LOCK1;
            csel  <= 1'b1;
          end
        end
        LOCK0, LOCK1: begin
          if (lock_xfer) begin
            if (rel_beat) begin
              state   <= IDLE;
              rr_last <= lock_src;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
      // A new error event in the same cycle as clr_err keeps the flag set.
      err_orphan <= set_orph | (err_orphan & ~clr_err);
      err_wdog   <= set_wdog | (err_wdog & ~clr_err);
    end
  end

endmodule
